// File: rtl/csa_mul_pkg.sv
// Shared definitions for the sequential carry-save multiplier: op codes, FSM states
// and the iteration counter width.
package csa_mul_pkg;

  // RV32M multiply op codes as presented on the op input
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StResolve,
    StDone
  } state_e;

  // Width of a counter that indexes multiplier bits 0..w-1 (at least one bit)
  function automatic int unsigned clog2(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/csa.sv
// Generic 3:2 carry-save adder. carry_o is unshifted: the caller weights it by two.
module csa #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] z_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);

  // Bitwise full-adder: sum and majority
  always_comb begin
    sum_o   = x_i ^ y_i ^ z_i;
    carry_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
  end

endmodule

// File: rtl/csa_mul_seq.sv
// Iterative RV32M multiplier: one multiplier bit per cycle into a carry-save accumulator,
// then a single carry-propagate add and sign correction.
// Optional macro CSA_MUL_EARLY_EXIT_EN: leave the accumulate phase as soon as no set
// multiplier bits remain.
module csa_mul_seq
  import csa_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = clog2(WIDTH);
  localparam int unsigned AccW = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  ma_q, ma_d;
  logic [WIDTH-1:0]  mb_q, mb_d;
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [AccW-1:0]   sum_q, sum_d;
  logic [AccW-1:0]   carry_q, carry_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              out_valid_q, out_valid_d;

  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH-1:0]  mb_sh;
  logic [AccW-1:0]   pp;
  logic [AccW-1:0]   csa_y;
  logic [AccW-1:0]   csa_sum, csa_carry;
  logic [AccW-1:0]   prod, prod_s;
  logic              acc_done;

  // Operand sign handling and magnitudes; 0x80..0 maps to 2^(WIDTH-1) as unsigned
  always_comb begin
    a_neg = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && a[WIDTH-1];
    b_neg = (op == MUL_OP_MULH) && b[WIDTH-1];
    a_mag = a_neg ? ((~a) + WIDTH'(1)) : a;
    b_mag = b_neg ? ((~b) + WIDTH'(1)) : b;
  end

  // Partial product and accumulate/resolve datapath terms
  always_comb begin
    mb_sh  = mb_q >> 1;
    pp     = mb_q[0] ? ({{WIDTH{1'b0}}, ma_q} << count_q) : '0;
    // Top carry bit shifted out here is always zero for in-range products
    csa_y  = carry_q << 1;
    prod   = sum_q + (carry_q << 1);
    prod_s = neg_q ? ((~prod) + AccW'(1)) : prod;
`ifdef CSA_MUL_EARLY_EXIT_EN
    acc_done = (count_q == CntW'(WIDTH - 1)) || (mb_sh == '0);
`else
    acc_done = (count_q == CntW'(WIDTH - 1));
`endif
  end

  csa #(
    .WIDTH (AccW)
  ) u_csa (
    .x_i     (sum_q),
    .y_i     (csa_y),
    .z_i     (pp),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );

  // Next-state logic; flush overrides everything including a same-cycle accept
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (in_valid) state_d = StAcc;
        StAcc:     if (acc_done) state_d = StResolve;
        StResolve: state_d = StDone;
        StDone:    if (out_ready) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Datapath next-state: latch on accept, accumulate, resolve, handshake
  always_comb begin
    ma_d        = ma_q;
    mb_d        = mb_q;
    op_d        = op_q;
    neg_d       = neg_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    count_d     = count_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            ma_d    = a_mag;
            mb_d    = b_mag;
            op_d    = op;
            neg_d   = a_neg ^ b_neg;
            sum_d   = '0;
            carry_d = '0;
            count_d = '0;
          end
        end
        StAcc: begin
          sum_d   = csa_sum;
          carry_d = csa_carry;
          mb_d    = mb_sh;
          count_d = count_q + CntW'(1);
        end
        StResolve: begin
          result_d    = (op_q == MUL_OP_MUL) ? prod_s[WIDTH-1:0] : prod_s[AccW-1:WIDTH];
          out_valid_d = 1'b1;
        end
        StDone: begin
          if (out_ready) out_valid_d = 1'b0;
        end
        default: out_valid_d = 1'b0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_q        <= '0;
      mb_q        <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      count_q     <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_csa_mul_seq.sv
// Directed bench for csa_mul_seq: products, latency, backpressure, flush and reset.
module tb_csa_mul_seq;

  localparam int unsigned W = 32;
  localparam int FullLat = W + 2;
`ifdef CSA_MUL_EARLY_EXIT_EN
  localparam int ShortLat = 3;
`else
  localparam int ShortLat = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csa_mul_seq #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // Issue one op from IDLE; returns at the negedge where out_valid is first seen.
  // cyc counts cycles with the accept cycle as 0.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] res, output int cyc, output bit to);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    to  = !out_valid;
    res = result;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      n_err++;
      $display("FAIL reset: out_valid=%b in_ready=%b result=%h, want 0 1 0",
               out_valid, in_ready, result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul_basic();
    logic [W-1:0] r; int c; bit to;
    run_op(2'b00, 32'd3, 32'd5, r, c, to);
    n_vec++;
    if (to || r !== 32'd15) begin
      n_err++;
      $display("FAIL mul_3x5: result=%h timeout=%b, want 0000000f", r, to);
    end
    n_vec++;
    if (c !== FullLat) begin
      n_err++;
      $display("FAIL mul_3x5_latency: cycle=%0d, want %0d", c, FullLat);
    end
  endtask

  typedef struct {
    logic [1:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp;
  } vec_t;

  task automatic test_ops();
    vec_t v[7];
    logic [W-1:0] r; int c; bit to;
    v[0] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    v[1] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    v[3] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    v[4] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    v[5] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6};
    v[6] = '{2'b10, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002};
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].o, v[i].x, v[i].y, r, c, to);
      n_vec++;
      if (to || r !== v[i].exp) begin
        n_err++;
        $display("FAIL op_vec%0d: op=%b a=%h b=%h result=%h timeout=%b, want %h",
                 i, v[i].o, v[i].x, v[i].y, r, to, v[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r; int c; bit to;
    run_op(2'b00, 32'd100, 32'd7, r, c, to);
    n_vec++;
    if (to || r !== 32'd700 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done: result=%h in_ready=%b, want 000002bc 0", r, in_ready);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_handoff: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r; int c; bit to; bit bad;
    out_ready = 1'b0;
    run_op(2'b00, 32'd12, 32'd12, r, c, to);
    bad = to;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 32'd144 || in_ready !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL backpressure_hold: out_valid=%b result=%h in_ready=%b, want 1 00000090 0",
               out_valid, result, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] r; int c; bit to; bit saw;
    @(negedge clk);
    op = 2'b00; a = 32'd123; b = 32'd456; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_abort: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    run_op(2'b00, 32'd4, 32'd4, r, c, to);
    n_vec++;
    if (to || r !== 32'd16 || c !== FullLat) begin
      n_err++;
      $display("FAIL flush_next: result=%h cycle=%0d, want 00000010 %0d", r, c, FullLat);
    end
    // flush beats a same-cycle request in IDLE
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) saw = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (saw) begin
      n_err++;
      $display("FAIL flush_vs_accept: request was accepted (saw busy/valid), want ignored");
    end
  endtask

  task automatic test_rst_mid();
    logic [W-1:0] r; int c; bit to;
    @(negedge clk);
    op = 2'b00; a = 32'd77; b = 32'd99; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      n_err++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b result=%h, want 0 1 0",
               out_valid, in_ready, result);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b11, 32'h0001_0000, 32'h0003_0000, r, c, to);
    n_vec++;
    if (to || r !== 32'h0000_0003) begin
      n_err++;
      $display("FAIL rst_recover: result=%h, want 00000003", r);
    end
  endtask

  task automatic test_early_exit();
    logic [W-1:0] r; int c; bit to;
    run_op(2'b00, 32'd9, 32'd1, r, c, to);
    n_vec++;
    if (to || r !== 32'd9 || c !== ShortLat) begin
      n_err++;
      $display("FAIL early_b1: result=%h cycle=%0d, want 00000009 %0d", r, c, ShortLat);
    end
    run_op(2'b00, 32'd55, 32'd0, r, c, to);
    n_vec++;
    if (to || r !== 32'd0 || c !== ShortLat) begin
      n_err++;
      $display("FAIL early_b0: result=%h cycle=%0d, want 00000000 %0d", r, c, ShortLat);
    end
    run_op(2'b00, 32'd2, 32'hFFFF_FFFF, r, c, to);
    n_vec++;
    if (to || r !== 32'hFFFF_FFFE || c !== FullLat) begin
      n_err++;
      $display("FAIL early_bfull: result=%h cycle=%0d, want fffffffe %0d", r, c, FullLat);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul_basic();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_early_exit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
